vec_dcache_port_arbiter: RTL and testbench
==========================================

Name: vec_dcache_port_arbiter

Overview:
- Shares one data-cache request port between NrPorts requesters: port 0 = PTW, port 1 = scalar load/store unit, port 2 = vector load/store unit.
- Arbitration is round-robin, with optional strict priority for port 0.
- Tracks outstanding transactions in an in-order FIFO of grant indices and routes each cache response back to its issuer.
- Sits between the LSU/PTW/vector unit and the write-through dcache request interface.

Parameters:
- NrPorts, 3, number of requesters (≥2).
- AddrWidth, 64, request address width.
- DataWidth, 64, read/write data width.
- MaxOutstanding, 7, depth of the outstanding-transaction FIFO.
- Port0Priority, 1, when 1 port 0 wins whenever it requests; when 0 it joins the round-robin.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NrPorts  per-port request valid
- req_ready_o  out  NrPorts  per-port request accepted
- req_addr_i  in  NrPorts*AddrWidth  per-port address
- req_we_i  in  NrPorts  per-port write enable
- req_be_i  in  NrPorts*DataWidth/8  per-port byte enables
- req_wdata_i  in  NrPorts*DataWidth  per-port write data
- cache_req_valid_o  out  1  request to dcache
- cache_req_ready_i  in  1  dcache accepts
- cache_req_addr_o  out  AddrWidth
- cache_req_we_o  out  1
- cache_req_be_o  out  DataWidth/8
- cache_req_wdata_o  out  DataWidth
- cache_rsp_valid_i  in  1  in-order response (one per accepted request, reads and writes)
- cache_rsp_rdata_i  in  DataWidth
- rsp_valid_o  out  NrPorts  one-hot response strobe
- rsp_rdata_o  out  DataWidth  response data, broadcast to all ports
- outstanding_o  out  $clog2(MaxOutstanding+1)  FIFO occupancy
- spurious_rsp_o  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, rst_ni low):
  - rr pointer = 0, FIFO empty, lock cleared, spurious_rsp_o = 0.
  - All valid/ready/strobe outputs = 0; data outputs = 0.
- States:
  - IDLE: no locked grant.
  - LOCKED: cache_req_valid_o was high without ready last cycle.
  - IDLE→LOCKED when valid && !ready; LOCKED→IDLE on handshake.
- Grant selection in IDLE:
  - If Port0Priority and req_valid_i[0], grant 0.
  - Otherwise grant the first valid port at or after the rr pointer, wrapping modulo NrPorts.
- In LOCKED the registered grant index is held; other requests are ignored until the handshake.
  - A requester must hold valid and payload stable until ready (protocol rule, asserted in the bench).
- Request datapath is a combinational mux of the granted port's payload; zero-cycle latency to the cache.
- cache_req_valid_o = granted port valid && !fifo_full.
- Full FIFO blocks a new grant even if a response pops in the same cycle.
  - A LOCKED request cannot coexist with a full FIFO, because the push happens only on handshake.
- req_ready_o[g] = cache_req_ready_i && cache_req_valid_o for the granted port g; 0 for all other ports.
- On handshake:
  - Push g into the FIFO.
  - rr pointer ← (g+1) mod NrPorts, updated only when g was chosen by round-robin (not by port 0 priority).
- On cache_rsp_valid_i with FIFO non-empty:
  - Pop the head.
  - rsp_valid_o = onehot(head), same cycle (combinational).
  - rsp_rdata_o = cache_rsp_rdata_i.
- On cache_rsp_valid_i with FIFO empty: no strobe; set spurious_rsp_o until reset.
- Simultaneous push and pop: occupancy unchanged, FIFO order preserved.
- FIFO pointers are $clog2(MaxOutstanding) bits with explicit wrap at MaxOutstanding-1, so non-power-of-2 depths work.
- outstanding_o is a registered occupancy count.

Decomposition:
- Shared package: port index type, port role constants (PORT_PTW=0, PORT_LSU=1, PORT_VLSU=2), request payload struct (addr, we, be, wdata).
- One sub-module, rr_outstanding_fifo: a generic in-order index FIFO with full/empty/count.
- The arbiter logic stays in the top module.

Test Plan:
- Ports 1 and 2 request continuously, ready=1, Port0Priority=0 → grants alternate 1,2,1,2; each response strobes the matching rsp_valid_o bit.
- Port 0 and port 2 request, Port0Priority=1 → port 0 granted every cycle, rr pointer unchanged; port 2 granted the cycle port 0 drops valid.
- Port 1 granted with ready=0 for 3 cycles while port 0 rises → grant stays on port 1 until the handshake; port 0 granted next.
- 7 requests accepted with no responses → cache_req_valid_o=0 and outstanding_o=7; a response plus a pending request in the same cycle → outstanding_o stays 7 on that cycle, grant happens next cycle.
- Response with FIFO empty → no rsp_valid_o strobe, spurious_rsp_o=1 and held until reset.
- Assert rst_ni low with 3 outstanding mid-transfer → all outputs 0 immediately, outstanding_o=0, rr pointer=0 after release.

Source files
------------

// File: rtl/vec_dcache_port_arbiter_pkg.sv
// Shared types for the dcache port arbiter: requester roles, grant index type,
// request payload layout and FSM state encoding.
package vec_dcache_port_arbiter_pkg;

   localparam int PORT_IDX_W     = 4;
   localparam int PAYLOAD_ADDR_W = 64;
   localparam int PAYLOAD_DATA_W = 64;

   typedef logic [PORT_IDX_W-1:0] port_idx_t;

   localparam port_idx_t PORT_PTW  = 4'd0;
   localparam port_idx_t PORT_LSU  = 4'd1;
   localparam port_idx_t PORT_VLSU = 4'd2;

   typedef struct packed {
      logic [PAYLOAD_ADDR_W-1:0]   addr;
      logic                        we;
      logic [PAYLOAD_DATA_W/8-1:0] be;
      logic [PAYLOAD_DATA_W-1:0]   wdata;
   } req_payload_t;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   // Next port index after idx, wrapping at n ports.
   function automatic port_idx_t wrap_inc(input port_idx_t idx, input int n);
      if (int'(idx) >= n - 1) return '0;
      else                    return idx + 1'b1;
   endfunction

endpackage

// File: rtl/vec_dcache_port_arbiter_rr_outstanding_fifo.sv
// In-order FIFO of grant indices; pointers wrap explicitly so any depth works.
module vec_dcache_port_arbiter_rr_outstanding_fifo #(
   parameter int Depth = 7,
   parameter int Width = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [Width-1:0]           data_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth+1)-1:0] count_o
);

   localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntWidth = $clog2(Depth + 1);

   logic [Width-1:0]    mem [Depth];
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [CntWidth-1:0] count_q;
   logic                do_push;
   logic                do_pop;

   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
      if (ptr == PtrWidth'(Depth - 1)) return '0;
      else                             return ptr + 1'b1;
   endfunction

   assign full_o  = (count_q == CntWidth'(Depth));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/vec_dcache_port_arbiter.sv
// Shares one dcache request port between PTW, scalar LSU and vector LSU with
// round-robin arbitration (optional PTW priority) and in-order response routing.
module vec_dcache_port_arbiter
   import vec_dcache_port_arbiter_pkg::*;
#(
   parameter int NrPorts        = 3,
   parameter int AddrWidth      = 64,
   parameter int DataWidth      = 64,
   parameter int MaxOutstanding = 7,
   parameter bit Port0Priority  = 1'b1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NrPorts-1:0]                  req_valid_i,
   output logic [NrPorts-1:0]                  req_ready_o,
   input  logic [NrPorts*AddrWidth-1:0]        req_addr_i,
   input  logic [NrPorts-1:0]                  req_we_i,
   input  logic [NrPorts*DataWidth/8-1:0]      req_be_i,
   input  logic [NrPorts*DataWidth-1:0]        req_wdata_i,
   output logic                                cache_req_valid_o,
   input  logic                                cache_req_ready_i,
   output logic [AddrWidth-1:0]                cache_req_addr_o,
   output logic                                cache_req_we_o,
   output logic [DataWidth/8-1:0]              cache_req_be_o,
   output logic [DataWidth-1:0]                cache_req_wdata_o,
   input  logic                                cache_rsp_valid_i,
   input  logic [DataWidth-1:0]                cache_rsp_rdata_i,
   output logic [NrPorts-1:0]                  rsp_valid_o,
   output logic [DataWidth-1:0]                rsp_rdata_o,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                                spurious_rsp_o
);

   localparam int BeWidth = DataWidth / 8;

   arb_state_t   state_q, state_d;
   port_idx_t    rr_q, rr_d;
   port_idx_t    lock_idx_q, lock_idx_d;
   logic         lock_rr_q, lock_rr_d;
   port_idx_t    grant_idx;
   logic         grant_rr;
   logic [NrPorts-1:0] grant_oh;
   logic         grant_valid;
   port_idx_t    low_any, low_rr;
   logic         hit_rr;
   port_idx_t    head_idx;
   logic         fifo_full, fifo_empty;
   logic         push, pop;
   logic         spurious_q;
   req_payload_t payload [NrPorts];
   req_payload_t sel;

   always_comb begin
      for (int i = 0; i < NrPorts; i++) begin
         payload[i].addr  = PAYLOAD_ADDR_W'(req_addr_i[i*AddrWidth +: AddrWidth]);
         payload[i].we    = req_we_i[i];
         payload[i].be    = (PAYLOAD_DATA_W/8)'(req_be_i[i*BeWidth +: BeWidth]);
         payload[i].wdata = PAYLOAD_DATA_W'(req_wdata_i[i*DataWidth +: DataWidth]);
      end
   end

   // Scan downwards so the lowest matching index wins: low_rr is the first valid
   // port at or above the pointer, low_any is the wrap-around fallback.
   always_comb begin
      low_any   = '0;
      low_rr    = '0;
      hit_rr    = 1'b0;
      grant_idx = lock_idx_q;
      grant_rr  = lock_rr_q;
      for (int i = NrPorts - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            low_any = port_idx_t'(i);
            if (port_idx_t'(i) >= rr_q) begin
               low_rr = port_idx_t'(i);
               hit_rr = 1'b1;
            end
         end
      end
      if (state_q == ARB_IDLE) begin
         if (Port0Priority && req_valid_i[0]) begin
            grant_idx = PORT_PTW;
            grant_rr  = 1'b0;
         end else begin
            grant_idx = hit_rr ? low_rr : low_any;
            grant_rr  = 1'b1;
         end
      end
   end

   always_comb begin
      sel = payload[0];
      for (int i = 0; i < NrPorts; i++) begin
         if (port_idx_t'(i) == grant_idx) sel = payload[i];
      end
   end

   assign grant_oh          = NrPorts'(1) << grant_idx;
   assign grant_valid       = |(req_valid_i & grant_oh);
   assign cache_req_valid_o = rst_ni & grant_valid & ~fifo_full;
   assign push              = cache_req_valid_o & cache_req_ready_i;
   assign req_ready_o       = push ? grant_oh : '0;

   // Payload and response data are forced to zero while reset is asserted.
   assign cache_req_addr_o  = rst_ni ? AddrWidth'(sel.addr)   : '0;
   assign cache_req_we_o    = rst_ni & sel.we;
   assign cache_req_be_o    = rst_ni ? BeWidth'(sel.be)       : '0;
   assign cache_req_wdata_o = rst_ni ? DataWidth'(sel.wdata)  : '0;

   assign pop            = rst_ni & cache_rsp_valid_i & ~fifo_empty;
   assign rsp_valid_o    = pop ? (NrPorts'(1) << head_idx) : '0;
   assign rsp_rdata_o    = rst_ni ? cache_rsp_rdata_i : '0;
   assign spurious_rsp_o = spurious_q;

   // A stalled request freezes the grant until it handshakes; the drop-valid
   // exit only guards against a requester breaking the hold rule.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      lock_rr_d  = lock_rr_q;
      rr_d       = rr_q;
      case (state_q)
         ARB_IDLE: begin
            if (cache_req_valid_o && !cache_req_ready_i) begin
               state_d    = ARB_LOCKED;
               lock_idx_d = grant_idx;
               lock_rr_d  = grant_rr;
            end
         end
         ARB_LOCKED: begin
            if (push || !cache_req_valid_o) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
      if (push && grant_rr) rr_d = wrap_inc(grant_idx, NrPorts);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB_IDLE;
         rr_q       <= '0;
         lock_idx_q <= '0;
         lock_rr_q  <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         lock_idx_q <= lock_idx_d;
         lock_rr_q  <= lock_rr_d;
         if (cache_rsp_valid_i && fifo_empty) spurious_q <= 1'b1;
      end
   end

   vec_dcache_port_arbiter_rr_outstanding_fifo #(
      .Depth (MaxOutstanding),
      .Width (PORT_IDX_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (grant_idx),
      .pop_i   (pop),
      .data_o  (head_idx),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (outstanding_o)
   );

endmodule

// File: tb/tb_vec_dcache_port_arbiter.sv
// Scoreboard bench: stimulus queues hand-computed grants/responses, a negedge
// monitor pops and compares whenever the arbiter presents a handshake or strobe.
module tb_vec_dcache_port_arbiter;
   import vec_dcache_port_arbiter_pkg::*;

   localparam int NP = 3;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int BW = 8;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NP-1:0]   req_valid;
   logic [NP*AW-1:0] req_addr;
   logic [NP-1:0]   req_we;
   logic [NP*BW-1:0] req_be;
   logic [NP*DW-1:0] req_wdata;
   logic            cache_req_ready;
   logic            cache_rsp_valid;
   logic [DW-1:0]   cache_rsp_rdata;

   logic [NP-1:0]   ready_a, rsp_valid_a, ready_b, rsp_valid_b;
   logic            cache_valid_a, cache_we_a, spur_a, cache_valid_b, cache_we_b, spur_b;
   logic [AW-1:0]   cache_addr_a, cache_addr_b;
   logic [BW-1:0]   cache_be_a, cache_be_b;
   logic [DW-1:0]   cache_wdata_a, rsp_rdata_a, cache_wdata_b, rsp_rdata_b;
   logic [CW-1:0]   outst_a, outst_b;

   typedef struct {
      int          port;
      logic [63:0] data;
   } rsp_t;

   int   checks = 0;
   int   errors = 0;
   int   exp_grant[$];
   rsp_t exp_rsp[$];
   int   mon_port;
   rsp_t mon_rsp;
   logic [NP-1:0] prev_pend;

   always #5 clk = ~clk;

   vec_dcache_port_arbiter #(
      .NrPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(7), .Port0Priority(1'b1)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(ready_a), .req_addr_i(req_addr),
      .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata),
      .cache_req_valid_o(cache_valid_a), .cache_req_ready_i(cache_req_ready),
      .cache_req_addr_o(cache_addr_a), .cache_req_we_o(cache_we_a),
      .cache_req_be_o(cache_be_a), .cache_req_wdata_o(cache_wdata_a),
      .cache_rsp_valid_i(cache_rsp_valid), .cache_rsp_rdata_i(cache_rsp_rdata),
      .rsp_valid_o(rsp_valid_a), .rsp_rdata_o(rsp_rdata_a),
      .outstanding_o(outst_a), .spurious_rsp_o(spur_a)
   );

   vec_dcache_port_arbiter #(
      .NrPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(7), .Port0Priority(1'b0)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(ready_b), .req_addr_i(req_addr),
      .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata),
      .cache_req_valid_o(cache_valid_b), .cache_req_ready_i(cache_req_ready),
      .cache_req_addr_o(cache_addr_b), .cache_req_we_o(cache_we_b),
      .cache_req_be_o(cache_be_b), .cache_req_wdata_o(cache_wdata_b),
      .cache_rsp_valid_i(cache_rsp_valid), .cache_rsp_rdata_i(cache_rsp_rdata),
      .rsp_valid_o(rsp_valid_b), .rsp_rdata_o(rsp_rdata_b),
      .outstanding_o(outst_b), .spurious_rsp_o(spur_b)
   );

   function automatic logic [63:0] port_addr(input int p);
      return 64'h1000 + 64'(p) * 64'h100;
   endfunction

   function automatic logic [63:0] port_wdata(input int p);
      return 64'hA5A5_0000 + 64'(p);
   endfunction

   function automatic logic [7:0] port_be(input int p);
      return 8'h11 << p;
   endfunction

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   task automatic apply_stimulus(input logic [NP-1:0] valid, input logic ready,
                                 input logic rspv, input logic [63:0] rdata);
      req_valid       = valid;
      cache_req_ready = ready;
      cache_rsp_valid = rspv;
      cache_rsp_rdata = rdata;
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   task automatic respond(input int port, input logic [63:0] data);
      exp_rsp.push_back('{port, data});
      apply_stimulus('0, 1'b1, 1'b1, data);
      to_next();
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
   endtask

   // One arbitration cycle for both instances: dut_a goes through the scoreboard,
   // dut_b (round-robin port 0) is compared directly.
   task automatic run_grant(input logic [NP-1:0] valid, input int grant_a, input logic [NP-1:0] ready_b_req);
      apply_stimulus(valid, 1'b1, 1'b0, 64'h0);
      exp_grant.push_back(grant_a);
      @(negedge clk);
      check_output("b_grant", 64'(ready_b), 64'(ready_b_req));
      to_next();
   endtask

   // Requesters in this bench must hold valid until accepted.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_pend <= '0;
      else begin
         for (int i = 0; i < NP; i++)
            if (prev_pend[i]) assert (req_valid[i]) else $error("[TB] protocol: port %0d dropped valid", i);
         prev_pend <= req_valid & ~ready_a;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ready_a !== '0) begin
            if (exp_grant.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL grant_unexpected actual=%b required=none", ready_a);
            end else begin
               mon_port = exp_grant.pop_front();
               check_output("grant_onehot", 64'(ready_a), 64'd1 << mon_port);
               check_output("grant_addr", cache_addr_a, port_addr(mon_port));
               check_output("grant_wdata", cache_wdata_a, port_wdata(mon_port));
               check_output("grant_be", 64'(cache_be_a), 64'(port_be(mon_port)));
               check_output("grant_we", 64'(cache_we_a), 64'(mon_port == int'(PORT_LSU)));
            end
         end
         if (rsp_valid_a !== '0) begin
            if (exp_rsp.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL rsp_unexpected actual=%b required=none", rsp_valid_a);
            end else begin
               mon_rsp = exp_rsp.pop_front();
               check_output("rsp_onehot", 64'(rsp_valid_a), 64'd1 << mon_rsp.port);
               check_output("rsp_rdata", rsp_rdata_a, mon_rsp.data);
            end
         end
      end
   end

   initial begin
      int a_grant [4];
      int b_grant [4];
      for (int p = 0; p < NP; p++) begin
         req_addr[p*AW +: AW]  = port_addr(p);
         req_wdata[p*DW +: DW] = port_wdata(p);
         req_be[p*BW +: BW]    = port_be(p);
         req_we[p]             = (p == int'(PORT_LSU));
      end

      // Reset with every input active: outputs must stay quiet.
      rst_n = 1'b0;
      apply_stimulus(3'b111, 1'b1, 1'b1, 64'h1234);
      #1;
      check_output("rst_cache_valid", 64'(cache_valid_a), 64'd0);
      check_output("rst_ready", 64'(ready_a), 64'd0);
      check_output("rst_rsp_valid", 64'(rsp_valid_a), 64'd0);
      check_output("rst_rsp_rdata", rsp_rdata_a, 64'd0);
      check_output("rst_addr", cache_addr_a, 64'd0);
      check_output("rst_outstanding", 64'(outst_a), 64'd0);
      check_output("rst_spurious", 64'(spur_a), 64'd0);
      repeat (2) to_next();
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
      rst_n = 1'b1;
      to_next();

      // LSU and VLSU contend: alternate 1,2,1,2.
      a_grant = '{int'(PORT_LSU), int'(PORT_VLSU), int'(PORT_LSU), int'(PORT_VLSU)};
      run_grant(3'b110, a_grant[0], 3'b010);
      run_grant(3'b110, a_grant[1], 3'b100);
      run_grant(3'b110, a_grant[2], 3'b010);
      run_grant(3'b100, a_grant[3], 3'b100);
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
      for (int i = 0; i < 4; i++) respond(a_grant[i], 64'hD000 + 64'(i));

      // PTW and VLSU: priority instance keeps port 0, round-robin instance alternates.
      b_grant = '{int'(PORT_PTW), int'(PORT_PTW), int'(PORT_PTW), int'(PORT_VLSU)};
      run_grant(3'b101, b_grant[0], 3'b001);
      run_grant(3'b101, b_grant[1], 3'b100);
      run_grant(3'b101, b_grant[2], 3'b001);
      run_grant(3'b100, b_grant[3], 3'b100);
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
      for (int i = 0; i < 4; i++) respond(b_grant[i], 64'hE000 + 64'(i));

      // Stalled LSU request stays granted while PTW arrives.
      for (int c = 0; c < 3; c++) begin
         apply_stimulus((c == 0) ? 3'b010 : 3'b011, 1'b0, 1'b0, 64'h0);
         @(negedge clk);
         check_output("lock_valid", 64'(cache_valid_a), 64'd1);
         check_output("lock_addr", cache_addr_a, port_addr(int'(PORT_LSU)));
         to_next();
      end
      apply_stimulus(3'b011, 1'b1, 1'b0, 64'h0);
      exp_grant.push_back(int'(PORT_LSU));
      to_next();
      apply_stimulus(3'b001, 1'b1, 1'b0, 64'h0);
      exp_grant.push_back(int'(PORT_PTW));
      to_next();
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
      respond(int'(PORT_LSU), 64'hC001);
      respond(int'(PORT_PTW), 64'hC002);

      // Fill all seven slots, then a response and a waiting request together.
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(3'b010, 1'b1, 1'b0, 64'h0);
         exp_grant.push_back(int'(PORT_LSU));
         to_next();
      end
      apply_stimulus(3'b010, 1'b1, 1'b0, 64'h0);
      @(negedge clk);
      check_output("full_valid", 64'(cache_valid_a), 64'd0);
      check_output("full_outstanding", 64'(outst_a), 64'd7);
      to_next();
      exp_rsp.push_back('{int'(PORT_LSU), 64'hF000});
      apply_stimulus(3'b010, 1'b1, 1'b1, 64'hF000);
      @(negedge clk);
      check_output("full_pop_valid", 64'(cache_valid_a), 64'd0);
      check_output("full_pop_outstanding", 64'(outst_a), 64'd7);
      to_next();
      apply_stimulus(3'b010, 1'b1, 1'b0, 64'h0);
      exp_grant.push_back(int'(PORT_LSU));
      @(negedge clk);
      check_output("refill_valid", 64'(cache_valid_a), 64'd1);
      check_output("refill_outstanding", 64'(outst_a), 64'd6);
      to_next();
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
      @(negedge clk);
      check_output("refull_outstanding", 64'(outst_a), 64'd7);
      to_next();
      for (int i = 0; i < 7; i++) respond(int'(PORT_LSU), 64'hF100 + 64'(i));
      @(negedge clk);
      check_output("drained_outstanding", 64'(outst_a), 64'd0);
      to_next();

      // Response with nothing outstanding.
      apply_stimulus('0, 1'b1, 1'b1, 64'hBAD);
      @(negedge clk);
      check_output("spurious_strobe", 64'(rsp_valid_a), 64'd0);
      to_next();
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
      @(negedge clk);
      check_output("spurious_set", 64'(spur_a), 64'd1);
      repeat (3) to_next();
      @(negedge clk);
      check_output("spurious_held", 64'(spur_a), 64'd1);
      to_next();

      // Reset in the middle of traffic with three outstanding.
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(3'b010, 1'b1, 1'b0, 64'h0);
         exp_grant.push_back(int'(PORT_LSU));
         to_next();
      end
      apply_stimulus(3'b010, 1'b1, 1'b1, 64'hFEED);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_cache_valid", 64'(cache_valid_a), 64'd0);
      check_output("midrst_ready", 64'(ready_a), 64'd0);
      check_output("midrst_rsp_valid", 64'(rsp_valid_a), 64'd0);
      check_output("midrst_rsp_rdata", rsp_rdata_a, 64'd0);
      check_output("midrst_addr", cache_addr_a, 64'd0);
      check_output("midrst_outstanding", 64'(outst_a), 64'd0);
      check_output("midrst_spurious", 64'(spur_a), 64'd0);
      to_next();
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
      to_next();
      rst_n = 1'b1;
      to_next();

      // Pointer back at 0: LSU wins over VLSU first.
      apply_stimulus(3'b110, 1'b1, 1'b0, 64'h0);
      exp_grant.push_back(int'(PORT_LSU));
      to_next();
      apply_stimulus(3'b100, 1'b1, 1'b0, 64'h0);
      exp_grant.push_back(int'(PORT_VLSU));
      to_next();
      apply_stimulus('0, 1'b1, 1'b0, 64'h0);
      respond(int'(PORT_LSU), 64'hAB01);
      respond(int'(PORT_VLSU), 64'hAB02);
      to_next();

      check_output("grant_queue_left", 64'(exp_grant.size()), 64'd0);
      check_output("rsp_queue_left", 64'(exp_rsp.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
